// File: rtl/counter_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_bus_ctrl
//  Description : AVR multiplexed-bus slave for four quadrature counters.
//                Serves counter bytes, status and clear strobes; optional
//                atomic snapshot when COUNTER_BUS_SNAPSHOT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module counter_bus_ctrl #(
    parameter int SIZE        = 9,
    parameter int LSIZE       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ale,
    input  logic             rd,
    input  logic             wr,
    input  logic [LSIZE-1:0] ad_in,
    output logic [LSIZE-1:0] ad_out,
    output logic             ad_oe,
    input  logic [SIZE-1:0]  count0,
    input  logic [SIZE-1:0]  count1,
    input  logic [SIZE-1:0]  count2,
    input  logic [SIZE-1:0]  count3,
    output logic [3:0]       clr
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ADDR  = 2'd1;
    localparam logic [1:0] c_READ  = 2'd2;
    localparam logic [1:0] c_WRITE = 2'd3;

    localparam logic [2:0] c_ADDR_STATUS = 3'd4;
    localparam logic [2:0] c_ADDR_SNAP   = 3'd5;

    logic [SYNC_STAGES-1:0]            r_ale_sync;
    logic [SYNC_STAGES-1:0]            r_rd_sync;
    logic [SYNC_STAGES-1:0]            r_wr_sync;
    logic                              r_ale_d;
    logic                              r_rd_d;
    logic                              r_wr_d;
    logic [SYNC_STAGES-1:0][LSIZE-1:0] r_ad_dly;

    logic             w_ale_s;
    logic             w_rd_s;
    logic             w_wr_s;
    logic             w_ale_fall;
    logic             w_rd_fall;
    logic             w_rd_rise;
    logic             w_wr_fall;
    logic             w_wr_rise;
    logic [LSIZE-1:0] w_ad_dly;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             w_load_addr;
    logic             w_load_rd;
    logic             w_commit;
    logic             w_set_err;
    logic             w_clr_err;

    logic [2:0]       r_addr;
    logic [LSIZE-1:0] r_ad_out;
    logic [3:0]       r_clr;
    logic             r_err;
    logic             w_snap_valid;
    logic [LSIZE-1:0] w_byte [4];
    logic [LSIZE-1:0] w_rd_data;
    logic             w_unused;

    // Strobe synchronisers; ad_in is delayed by the same depth so the
    // captured address/data lines up with the strobe that qualifies it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ale_sync <= '0;
            r_rd_sync  <= '1;
            r_wr_sync  <= '1;
            r_ale_d    <= 1'b0;
            r_rd_d     <= 1'b1;
            r_wr_d     <= 1'b1;
            r_ad_dly   <= '0;
        end else begin
            r_ale_sync <= {r_ale_sync[SYNC_STAGES-2:0], ale};
            r_rd_sync  <= {r_rd_sync[SYNC_STAGES-2:0], rd};
            r_wr_sync  <= {r_wr_sync[SYNC_STAGES-2:0], wr};
            r_ale_d    <= w_ale_s;
            r_rd_d     <= w_rd_s;
            r_wr_d     <= w_wr_s;
            r_ad_dly   <= {r_ad_dly[SYNC_STAGES-2:0], ad_in};
        end
    end

    assign w_ale_s    = r_ale_sync[SYNC_STAGES-1];
    assign w_rd_s     = r_rd_sync[SYNC_STAGES-1];
    assign w_wr_s     = r_wr_sync[SYNC_STAGES-1];
    assign w_ad_dly   = r_ad_dly[SYNC_STAGES-1];
    assign w_ale_fall = r_ale_d & ~w_ale_s;
    assign w_rd_fall  = r_rd_d & ~w_rd_s;
    assign w_rd_rise  = ~r_rd_d & w_rd_s;
    assign w_wr_fall  = r_wr_d & ~w_wr_s;
    assign w_wr_rise  = ~r_wr_d & w_wr_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A new address phase wins over anything in flight and aborts it.
    always_comb begin
        w_next_state = r_state;
        w_load_addr  = 1'b0;
        w_load_rd    = 1'b0;
        w_commit     = 1'b0;
        w_set_err    = 1'b0;
        w_clr_err    = 1'b0;
        if (w_ale_fall) begin
            w_next_state = c_ADDR;
            w_load_addr  = 1'b1;
        end else begin
            case (r_state)
                c_ADDR: begin
                    if (w_rd_fall && w_wr_fall) begin
                        w_set_err = 1'b1;
                    end else if (w_rd_fall) begin
                        w_next_state = c_READ;
                        w_load_rd    = 1'b1;
                    end else if (w_wr_fall) begin
                        w_next_state = c_WRITE;
                    end
                end
                c_READ: begin
                    if (w_rd_rise) begin
                        w_next_state = c_IDLE;
                        w_clr_err    = (r_addr == c_ADDR_STATUS);
                    end
                end
                c_WRITE: begin
                    if (w_wr_rise) begin
                        w_next_state = c_IDLE;
                        w_commit     = 1'b1;
                    end
                end
                default: begin
                    w_next_state = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_ad_out <= '0;
            r_clr    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_clr <= '0;
            if (w_load_addr) begin
                r_addr <= w_ad_dly[2:0];
            end
            if (w_load_rd) begin
                r_ad_out <= w_rd_data;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end else if (w_clr_err) begin
                r_err <= 1'b0;
            end
            if (w_commit && (r_addr == c_ADDR_STATUS)) begin
                r_clr <= w_ad_dly[3:0];
            end
        end
    end

`ifdef COUNTER_BUS_SNAPSHOT_EN
    logic [3:0][LSIZE-1:0] r_snap;
    logic                  r_snap_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap       <= '0;
            r_snap_valid <= 1'b0;
        end else if (w_commit && (r_addr == c_ADDR_SNAP)) begin
            r_snap[0]    <= count0[LSIZE:1];
            r_snap[1]    <= count1[LSIZE:1];
            r_snap[2]    <= count2[LSIZE:1];
            r_snap[3]    <= count3[LSIZE:1];
            r_snap_valid <= 1'b1;
        end else if (w_commit && (r_addr == c_ADDR_STATUS)) begin
            r_snap_valid <= 1'b0;
        end
    end

    assign w_snap_valid = r_snap_valid;
    assign w_byte[0]    = r_snap[0];
    assign w_byte[1]    = r_snap[1];
    assign w_byte[2]    = r_snap[2];
    assign w_byte[3]    = r_snap[3];
`else
    assign w_snap_valid = 1'b0;
    assign w_byte[0]    = count0[LSIZE:1];
    assign w_byte[1]    = count1[LSIZE:1];
    assign w_byte[2]    = count2[LSIZE:1];
    assign w_byte[3]    = count3[LSIZE:1];
`endif

    always_comb begin
        w_rd_data = '0;
        case (r_addr)
            3'd0:          w_rd_data = w_byte[0];
            3'd1:          w_rd_data = w_byte[1];
            3'd2:          w_rd_data = w_byte[2];
            3'd3:          w_rd_data = w_byte[3];
            c_ADDR_STATUS: w_rd_data = {r_err, {(LSIZE-2){1'b0}}, w_snap_valid};
            default:       w_rd_data = '0;
        endcase
    end

    // Counter LSBs and high data bits are intentionally not consumed.
    assign w_unused = ^{count0, count1, count2, count3, w_ad_dly};

    assign ad_out = r_ad_out;
    assign ad_oe  = (r_state == c_READ);
    assign clr    = r_clr;

endmodule
`default_nettype wire

// File: tb/tb_counter_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_bus_ctrl
//  Description : Self-checking bench for counter_bus_ctrl with a behavioural
//                bus/register model and randomised bus transactions.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_counter_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ale;
    logic       rd;
    logic       wr;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [8:0] count0;
    logic [8:0] count1;
    logic [8:0] count2;
    logic [8:0] count3;
    logic [3:0] clr;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] m_snap [4];
    bit         m_snap_valid;
    bit         m_err;

    counter_bus_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .ale   (ale),
        .rd    (rd),
        .wr    (wr),
        .ad_in (ad_in),
        .ad_out(ad_out),
        .ad_oe (ad_oe),
        .count0(count0),
        .count1(count1),
        .count2(count2),
        .count3(count3),
        .clr   (clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] cnt_byte(input logic [8:0] c);
        return 8'((c >> 1) & 9'h0FF);
    endfunction

    function automatic logic [8:0] live(input int i);
        case (i)
            0:       return count0;
            1:       return count1;
            2:       return count2;
            default: return count3;
        endcase
    endfunction

    function automatic logic [7:0] exp_read(input int a);
        if (a < 4) begin
`ifdef COUNTER_BUS_SNAPSHOT_EN
            return m_snap[a];
`else
            return cnt_byte(live(a));
`endif
        end
        if (a == 4) return (m_err ? 8'h80 : 8'h00) | (m_snap_valid ? 8'h01 : 8'h00);
        return 8'h00;
    endfunction

    task automatic model_write(input int a);
        if (a == 4) m_snap_valid = 0;
`ifdef COUNTER_BUS_SNAPSHOT_EN
        if (a == 5) begin
            for (int i = 0; i < 4; i++) m_snap[i] = cnt_byte(live(i));
            m_snap_valid = 1;
        end
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_snap[i] = 8'h00;
        m_snap_valid = 0;
        m_err        = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic watch(input int n, inout bit saw_clr, inout bit saw_oe);
        repeat (n) begin
            tick();
            if (clr !== 4'b0) saw_clr = 1;
            if (ad_oe !== 1'b0) saw_oe = 1;
        end
    endtask

    task automatic bus_addr(input logic [7:0] a);
        ad_in = a;
        ale   = 1'b1;
        repeat (4) tick();
        ale = 1'b0;
        repeat (5) tick();
    endtask

    task automatic bus_read(input logic [7:0] a, input bit wiggle, output logic [7:0] data,
                            output int rise_n, output int fall_n, output bit stable);
        bus_addr(a);
        rd     = 1'b0;
        rise_n = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (ad_oe === 1'b1) begin
                rise_n = n;
                break;
            end
        end
        data   = ad_out;
        stable = 1;
        repeat (7) begin
            if (wiggle) count2 = 9'($urandom);
            tick();
            if (ad_out !== data || ad_oe !== 1'b1) stable = 0;
        end
        rd     = 1'b1;
        fall_n = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (ad_oe === 1'b0) begin
                fall_n = n;
                break;
            end
        end
        repeat (2) tick();
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d, output logic [3:0] clr_val,
                             output int pulses, output int first_n);
        bus_addr(a);
        ad_in   = d;
        pulses  = 0;
        clr_val = 4'b0;
        first_n = -1;
        wr      = 1'b0;
        repeat (6) begin
            tick();
            if (clr !== 4'b0) begin
                pulses++;
                clr_val = clr_val | clr;
            end
        end
        wr = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (clr !== 4'b0) begin
                pulses++;
                clr_val = clr_val | clr;
                if (first_n < 0) first_n = n;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic [7:0] e;
        int         r, f;
        bit         s;
        rst = 1'b1; ale = 1'b0; rd = 1'b1; wr = 1'b1; ad_in = 8'h00;
        count0 = 9'h0; count1 = 9'h0; count2 = 9'h0; count3 = 9'h0;
        model_reset();
        repeat (3) tick();
        n_cmp++;
        if (ad_oe !== 1'b0 || clr !== 4'b0 || ad_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got oe=%b clr=%b ad_out=%h, expected 0/0000/00", ad_oe, clr, ad_out);
        end
        rst = 1'b0;
        repeat (3) tick();
        e = exp_read(4);
        bus_read(8'h04, 0, d, r, f, s);
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL reset_status: got %h expected %h", d, e);
        end
    endtask

    task automatic test_read_count2();
        logic [7:0] d;
        logic [7:0] e;
        int         r, f;
        bit         s;
        count2 = 9'h0A6;
        e = exp_read(2);
        bus_read(8'h02, 1, d, r, f, s);
        n_cmp++;
        if (r !== 3) begin
            n_bad++;
            $display("FAIL read_oe_rise: got %0d cycles expected 3", r);
        end
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL read_count2_data: got %h expected %h", d, e);
        end
        n_cmp++;
        if (s !== 1'b1) begin
            n_bad++;
            $display("FAIL read_frozen: ad_out/ad_oe changed during read, got %b expected 1", s);
        end
        n_cmp++;
        if (f !== 3) begin
            n_bad++;
            $display("FAIL read_oe_fall: got %0d cycles expected 3", f);
        end
    endtask

    task automatic test_clr_write();
        logic [3:0] cv;
        int         p, fn;
        bus_write(8'h04, 8'h05, cv, p, fn);
        model_write(4);
        n_cmp++;
        if (cv !== 4'b0101 || p !== 1) begin
            n_bad++;
            $display("FAIL clr_pulse: got mask=%b cycles=%0d expected 0101/1", cv, p);
        end
        n_cmp++;
        if (fn !== 3) begin
            n_bad++;
            $display("FAIL clr_timing: got %0d cycles after wr rise expected 3", fn);
        end
    endtask

    task automatic test_err();
        logic [7:0] d;
        logic [7:0] e;
        int         r, f;
        bit         s;
        bit         sc = 0;
        bit         so = 0;
        bus_addr(8'h04);
        rd = 1'b0;
        wr = 1'b0;
        watch(6, sc, so);
        rd = 1'b1;
        wr = 1'b1;
        watch(4, sc, so);
        m_err = 1;
        n_cmp++;
        if (sc || so) begin
            n_bad++;
            $display("FAIL err_no_activity: got clr_seen=%b oe_seen=%b expected 0/0", sc, so);
        end
        e = exp_read(4);
        bus_read(8'h04, 0, d, r, f, s);
        m_err = 0;
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL err_status_set: got %h expected %h", d, e);
        end
        e = exp_read(4);
        bus_read(8'h04, 0, d, r, f, s);
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL err_status_cleared: got %h expected %h", d, e);
        end
    endtask

    task automatic test_snapshot();
        logic [3:0] cv;
        int         p, fn, r, f;
        logic [7:0] d;
        logic [7:0] e;
        bit         s;
        count0 = 9'h010;
        bus_write(8'h05, 8'($urandom), cv, p, fn);
        model_write(5);
        n_cmp++;
        if (p !== 0) begin
            n_bad++;
            $display("FAIL snap_no_clr: got %0d clr cycles expected 0", p);
        end
        count0 = 9'h1FE;
        e = exp_read(0);
        bus_read(8'h00, 0, d, r, f, s);
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL snap_read0: got %h expected %h", d, e);
        end
        e = exp_read(4);
        bus_read(8'h04, 0, d, r, f, s);
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL snap_status: got %h expected %h", d, e);
        end
    endtask

    task automatic test_abort();
        bit         sc = 0;
        bit         so = 0;
        logic [7:0] d;
        logic [7:0] e;
        int         r;
        count2 = 9'h155;
        bus_addr(8'h04);
        ad_in = 8'h05;
        wr    = 1'b0;
        watch(5, sc, so);
        ad_in = 8'h02;
        ale   = 1'b1;
        watch(4, sc, so);
        ale = 1'b0;
        watch(5, sc, so);
        wr = 1'b1;
        watch(5, sc, so);
        n_cmp++;
        if (sc || so) begin
            n_bad++;
            $display("FAIL abort_no_commit: got clr_seen=%b oe_seen=%b expected 0/0", sc, so);
        end
        e  = exp_read(2);
        rd = 1'b0;
        r  = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (ad_oe === 1'b1) begin
                r = n;
                break;
            end
        end
        d = ad_out;
        repeat (3) tick();
        rd = 1'b1;
        repeat (6) tick();
        n_cmp++;
        if (r !== 3 || d !== e) begin
            n_bad++;
            $display("FAIL abort_new_addr: got rise=%0d data=%h expected 3/%h", r, d, e);
        end
    endtask

    task automatic test_reset_midread();
        bit         sc = 0;
        bit         so = 0;
        logic [7:0] d;
        int         r, f;
        bit         s;
        bus_addr(8'h00);
        rd = 1'b0;
        wr = 1'b0;
        watch(6, sc, so);
        rd = 1'b1;
        wr = 1'b1;
        watch(4, sc, so);
        bus_addr(8'h01);
        rd = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (ad_oe === 1'b1) break;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ad_oe !== 1'b0 || clr !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_async: got oe=%b clr=%b expected 0/0000", ad_oe, clr);
        end
        rd = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        repeat (4) tick();
        bus_read(8'h04, 0, d, r, f, s);
        n_cmp++;
        if (d !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_status_after: got %h expected 00", d);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [7:0] e;
        logic [7:0] a;
        logic [7:0] wd;
        logic [3:0] cv;
        int         r, f, p, fn, ep;
        bit         s;
        for (int it = 0; it < 40; it++) begin
            count0 = 9'($urandom);
            count1 = 9'($urandom);
            count2 = 9'($urandom);
            count3 = 9'($urandom);
            a      = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                e = exp_read(int'(a[2:0]));
                bus_read(a, 0, d, r, f, s);
                if (a[2:0] == 3'd4) m_err = 0;
                n_cmp++;
                if (d !== e || r !== 3) begin
                    n_bad++;
                    $display("FAIL rand_read[%0d] addr=%h: got data=%h rise=%0d expected %h/3", it, a, d, r, e);
                end
            end else begin
                wd = 8'($urandom);
                ep = (a[2:0] == 3'd4 && wd[3:0] != 4'b0) ? 1 : 0;
                bus_write(a, wd, cv, p, fn);
                model_write(int'(a[2:0]));
                n_cmp++;
                if (p !== ep || (ep == 1 && cv !== wd[3:0])) begin
                    n_bad++;
                    $display("FAIL rand_write[%0d] addr=%h data=%h: got cycles=%0d mask=%b expected %0d/%b",
                             it, a, wd, p, cv, ep, wd[3:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_count2();
        test_clr_write();
        test_err();
        test_snapshot();
        test_abort();
        test_random();
        test_reset_midread();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
